// File: rtl/miv_ram_ecc_scrub.sv
// miv_ram_ecc_scrub: 1W/1R RAM with SECDED ECC, per-read error flags,
// saturating error counters, error-address capture and a scrub-on-read
// write-back engine for single-bit errors.
//
// Codeword layout: bit 0 is overall parity, bits 1..N hold the Hamming
// code with check bits at power-of-two positions and data bits filling the
// remaining positions in ascending order.
//
// Timing: RD, RD_VALID, SB_CORRECT and DB_DETECT present a read 1+RD_PIPE
// cycles after REN. ERR_ADDR, SB_CNT, DB_CNT, SCRUB_BUSY and SCRUB_DROP
// update on the clock edge that ends the RD_VALID cycle.
module miv_ram_ecc_scrub #(
  parameter int unsigned DATA_W   = 21,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned ECC_EN   = 1,
  parameter int unsigned RD_PIPE  = 0,
  parameter int unsigned SCRUB_EN = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] RADDR,
  input  logic              REN,
  input  logic              INJ_SB,
  input  logic              INJ_DB,
  input  logic              CNT_CLR,
  output logic [DATA_W-1:0] RD,
  output logic              RD_VALID,
  output logic              SB_CORRECT,
  output logic              DB_DETECT,
  output logic [ADDR_W-1:0] ERR_ADDR,
  output logic [CNT_W-1:0]  SB_CNT,
  output logic [CNT_W-1:0]  DB_CNT,
  output logic              SCRUB_BUSY,
  output logic              SCRUB_DROP
);

  // Smallest number of Hamming check bits covering data plus check bits.
  function automatic int unsigned calc_p(input int unsigned dw);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < (dw + p + 32'd1)) p++;
    return p;
  endfunction

  localparam int unsigned P     = calc_p(DATA_W);
  localparam int unsigned N     = DATA_W + P;
  localparam int unsigned CW_W  = N + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CIW   = $clog2(CW_W);
  localparam int unsigned DIW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic        SCRUB_ON = (SCRUB_EN != 0) && (ECC_EN != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } scrub_state_e;

  // Build a SECDED codeword from payload data.
  function automatic logic [CW_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    int unsigned     k;
    cw = '0;
    k  = 0;
    for (int unsigned j = 1; j <= N; j++) begin
      if ((j & (j - 32'd1)) != 0) begin
        cw[CIW'(j)] = d[DIW'(k)];
        k++;
      end
    end
    for (int unsigned p = 0; p < P; p++) begin
      for (int unsigned j = 1; j <= N; j++) begin
        if ((((j >> p) & 32'd1) != 0) && (j != (32'd1 << p)))
          cw[CIW'(32'd1 << p)] = cw[CIW'(32'd1 << p)] ^ cw[CIW'(j)];
      end
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  // Syndrome = XOR of the positions of all set Hamming bits.
  function automatic logic [P-1:0] ecc_syn(input logic [CW_W-1:0] cw);
    int unsigned s;
    s = 0;
    for (int unsigned j = 1; j <= N; j++) begin
      if (cw[CIW'(j)]) s = s ^ j;
    end
    return P'(s);
  endfunction

  // Pull payload bits back out of the non-power-of-two positions.
  function automatic logic [DATA_W-1:0] ecc_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int unsigned       k;
    d = '0;
    k = 0;
    for (int unsigned j = 1; j <= N; j++) begin
      if ((j & (j - 32'd1)) != 0) begin
        d[DIW'(k)] = cw[CIW'(j)];
        k++;
      end
    end
    return d;
  endfunction

  logic [CW_W-1:0]   mem [DEPTH];

  logic [CW_W-1:0]   inj_c;
  logic [CW_W-1:0]   wr_cw_c;

  logic              v1_q;
  logic              stale1_q;
  logic [CW_W-1:0]   cw1_q;
  logic [ADDR_W-1:0] addr1_q;

  logic [P-1:0]      syn_c;
  logic              ovr_c;
  logic [CW_W-1:0]   corr_c;
  logic              dec_sb_c;
  logic              dec_db_c;
  logic [DATA_W-1:0] dec_data_c;
  logic [CW_W-1:0]   fix_cw_c;

  logic              f_valid;
  logic              f_sb;
  logic              f_db;
  logic              f_stale;
  logic [DATA_W-1:0] f_rd;
  logic [ADDR_W-1:0] f_addr;
  logic [CW_W-1:0]   f_cw;

  logic              sb_ev_c;
  logic              db_ev_c;
  logic              stale_hit_c;

  scrub_state_e      scrub_st_q;
  logic [ADDR_W-1:0] scrub_addr_q;
  logic [CW_W-1:0]   scrub_cw_q;
  logic              drop_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [CNT_W-1:0]  sb_cnt_q;
  logic [CNT_W-1:0]  db_cnt_q;

  // Write codeword with optional test-injection mask.
  always_comb begin
    inj_c = '0;
    if (ECC_EN != 0) begin
      if (INJ_DB)      inj_c = CW_W'(2'b11);
      else if (INJ_SB) inj_c = CW_W'(2'b01);
    end
    wr_cw_c = (ECC_EN != 0) ? (ecc_encode(WD) ^ inj_c) : CW_W'(WD);
  end

  // Array write port: user writes win, otherwise a pending scrub writes back.
  always_ff @(posedge CLK) begin
    if (WEN) mem[WADDR] <= wr_cw_c;
    else if (scrub_st_q == S_PEND) mem[scrub_addr_q] <= scrub_cw_q;
  end

  // Array read register; stale marks a same-edge overwrite of the read row.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      v1_q     <= 1'b0;
      stale1_q <= 1'b0;
      cw1_q    <= '0;
      addr1_q  <= '0;
    end else begin
      v1_q <= REN;
      if (REN) begin
        cw1_q    <= mem[RADDR];
        addr1_q  <= RADDR;
        stale1_q <= WEN && (WADDR == RADDR);
      end
    end
  end

  // SECDED decode of the registered codeword.
  always_comb begin
    syn_c      = ecc_syn(cw1_q);
    ovr_c      = ^cw1_q;
    corr_c     = cw1_q;
    dec_sb_c   = 1'b0;
    dec_db_c   = 1'b0;
    dec_data_c = cw1_q[DATA_W-1:0];
    if (ECC_EN != 0) begin
      if (ovr_c && (32'(syn_c) <= N)) begin
        dec_sb_c = 1'b1;
        if (syn_c != '0) corr_c[CIW'(syn_c)] = ~corr_c[CIW'(syn_c)];
      end else if (syn_c != '0) begin
        dec_db_c = 1'b1;
      end
      dec_data_c = ecc_data(corr_c);
    end
    fix_cw_c = ecc_encode(dec_data_c);
  end

  generate
    if (RD_PIPE != 0) begin : g_pipe
      logic              v2_q;
      logic              sb2_q;
      logic              db2_q;
      logic              stale2_q;
      logic [DATA_W-1:0] rd2_q;
      logic [ADDR_W-1:0] addr2_q;
      logic [CW_W-1:0]   cw2_q;

      // Extra output register stage; address and staleness travel along.
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          v2_q     <= 1'b0;
          sb2_q    <= 1'b0;
          db2_q    <= 1'b0;
          stale2_q <= 1'b0;
          rd2_q    <= '0;
          addr2_q  <= '0;
          cw2_q    <= '0;
        end else begin
          v2_q     <= v1_q;
          sb2_q    <= dec_sb_c;
          db2_q    <= dec_db_c;
          stale2_q <= stale1_q || (WEN && (WADDR == addr1_q));
          rd2_q    <= dec_data_c;
          addr2_q  <= addr1_q;
          cw2_q    <= fix_cw_c;
        end
      end

      assign f_valid = v2_q;
      assign f_sb    = sb2_q;
      assign f_db    = db2_q;
      assign f_stale = stale2_q;
      assign f_rd    = rd2_q;
      assign f_addr  = addr2_q;
      assign f_cw    = cw2_q;
    end else begin : g_nopipe
      assign f_valid = v1_q;
      assign f_sb    = dec_sb_c;
      assign f_db    = dec_db_c;
      assign f_stale = stale1_q;
      assign f_rd    = dec_data_c;
      assign f_addr  = addr1_q;
      assign f_cw    = fix_cw_c;
    end
  endgenerate

  assign sb_ev_c     = f_valid && f_sb;
  assign db_ev_c     = f_valid && f_db;
  assign stale_hit_c = f_stale || (WEN && (WADDR == f_addr));

  // Scrub engine: hold one corrected row and write it back in a WEN=0 cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      scrub_st_q   <= S_IDLE;
      scrub_addr_q <= '0;
      scrub_cw_q   <= '0;
    end else begin
      case (scrub_st_q)
        S_IDLE: begin
          if (SCRUB_ON && sb_ev_c && !stale_hit_c) begin
            scrub_st_q   <= S_PEND;
            scrub_addr_q <= f_addr;
            scrub_cw_q   <= f_cw;
          end
        end
        S_PEND: begin
          if (!WEN || (WADDR == scrub_addr_q)) scrub_st_q <= S_IDLE;
        end
        default: scrub_st_q <= S_IDLE;
      endcase
    end
  end

  // Sticky drop flag for SB write-backs that found the engine occupied.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      drop_q <= 1'b0;
    end else if (SCRUB_ON && sb_ev_c && (scrub_st_q == S_PEND)) begin
      drop_q <= 1'b1;
    end else if (CNT_CLR) begin
      drop_q <= 1'b0;
    end
  end

  // Error address capture and saturating error counters.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      err_addr_q <= '0;
      sb_cnt_q   <= '0;
      db_cnt_q   <= '0;
    end else begin
      if (sb_ev_c || db_ev_c) err_addr_q <= f_addr;
      if (CNT_CLR) begin
        sb_cnt_q <= CNT_W'(sb_ev_c);
        db_cnt_q <= CNT_W'(db_ev_c);
      end else begin
        if (sb_ev_c && (sb_cnt_q != CNT_MAX)) sb_cnt_q <= sb_cnt_q + 1'b1;
        if (db_ev_c && (db_cnt_q != CNT_MAX)) db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign RD         = f_rd;
  assign RD_VALID   = f_valid;
  assign SB_CORRECT = sb_ev_c;
  assign DB_DETECT  = db_ev_c;
  assign ERR_ADDR   = err_addr_q;
  assign SB_CNT     = sb_cnt_q;
  assign DB_CNT     = db_cnt_q;
  assign SCRUB_BUSY = (scrub_st_q == S_PEND);
  assign SCRUB_DROP = drop_q;

endmodule

// File: tb/tb_miv_ram_ecc_scrub.sv
// Directed bench for miv_ram_ecc_scrub: default instance (a) plus a
// CNT_W=2 / RD_PIPE=1 instance (b) sharing the same input stimulus.
module tb_miv_ram_ecc_scrub;

  logic        CLK;
  logic        RESETN;
  logic [20:0] WD;
  logic [6:0]  WADDR;
  logic        WEN;
  logic [6:0]  RADDR;
  logic        REN;
  logic        INJ_SB;
  logic        INJ_DB;
  logic        CNT_CLR;

  logic [20:0] rd_a, rd_b;
  logic        rv_a, rv_b, sb_a, sb_b, db_a, db_b;
  logic [6:0]  ea_a, ea_b;
  logic [7:0]  sbc_a, dbc_a;
  logic [1:0]  sbc_b, dbc_b;
  logic        busy_a, busy_b, drop_a, drop_b;

  int n_vec = 0;
  int n_bad = 0;

  miv_ram_ecc_scrub u_dut_a (
    .CLK(CLK), .RESETN(RESETN), .WD(WD), .WADDR(WADDR), .WEN(WEN),
    .RADDR(RADDR), .REN(REN), .INJ_SB(INJ_SB), .INJ_DB(INJ_DB),
    .CNT_CLR(CNT_CLR), .RD(rd_a), .RD_VALID(rv_a), .SB_CORRECT(sb_a),
    .DB_DETECT(db_a), .ERR_ADDR(ea_a), .SB_CNT(sbc_a), .DB_CNT(dbc_a),
    .SCRUB_BUSY(busy_a), .SCRUB_DROP(drop_a)
  );

  miv_ram_ecc_scrub #(.CNT_W(2), .RD_PIPE(1)) u_dut_b (
    .CLK(CLK), .RESETN(RESETN), .WD(WD), .WADDR(WADDR), .WEN(WEN),
    .RADDR(RADDR), .REN(REN), .INJ_SB(INJ_SB), .INJ_DB(INJ_DB),
    .CNT_CLR(CNT_CLR), .RD(rd_b), .RD_VALID(rv_b), .SB_CORRECT(sb_b),
    .DB_DETECT(db_b), .ERR_ADDR(ea_b), .SB_CNT(sbc_b), .DB_CNT(dbc_b),
    .SCRUB_BUSY(busy_b), .SCRUB_DROP(drop_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0]  addr;
    logic [20:0] wd;
    logic        inj_sb;
    logic        inj_db;
    logic        exp_sb;
    logic        exp_db;
    logic [6:0]  exp_err;
    logic [7:0]  exp_sbc;
    logic [7:0]  exp_dbc;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WEN = 1'b0; REN = 1'b0; INJ_SB = 1'b0; INJ_DB = 1'b0; CNT_CLR = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [20:0] d, input logic isb, input logic idb);
    WEN = 1'b1; WADDR = a; WD = d; INJ_SB = isb; INJ_DB = idb;
    cyc();
    idle();
  endtask

  // Issue a read; on return instance a shows the result.
  task automatic rd_issue(input logic [6:0] a);
    REN = 1'b1; RADDR = a;
    cyc();
    idle();
  endtask

  initial begin
    tbl[0] = '{7'h05, 21'h0ABCDE, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'd0, 8'd0, 1'b0};
    tbl[1] = '{7'h10, 21'h155555, 1'b1, 1'b0, 1'b1, 1'b0, 7'h10, 8'd1, 8'd0, 1'b1};
    tbl[2] = '{7'h7F, 21'h000001, 1'b0, 1'b1, 1'b0, 1'b1, 7'h7F, 8'd1, 8'd1, 1'b0};
    tbl[3] = '{7'h20, 21'h1FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 7'h7F, 8'd1, 8'd1, 1'b0};
    tbl[4] = '{7'h21, 21'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 7'h21, 8'd2, 8'd1, 1'b1};
    tbl[5] = '{7'h22, 21'h100000, 1'b1, 1'b1, 1'b0, 1'b1, 7'h22, 8'd2, 8'd2, 1'b0};

    idle();
    WD = '0; WADDR = '0; RADDR = '0;
    RESETN = 1'b0;
    cyc(); cyc();
    chk("rst_rd",    32'(rd_a),   32'h0);
    chk("rst_valid", 32'(rv_a),   32'h0);
    chk("rst_sb",    32'(sb_a),   32'h0);
    chk("rst_db",    32'(db_a),   32'h0);
    chk("rst_err",   32'(ea_a),   32'h0);
    chk("rst_sbc",   32'(sbc_a),  32'h0);
    chk("rst_dbc",   32'(dbc_a),  32'h0);
    chk("rst_busy",  32'(busy_a), 32'h0);
    chk("rst_drop",  32'(drop_a), 32'h0);
    chk("rst_valid_b", 32'(rv_b), 32'h0);
    RESETN = 1'b1;
    cyc();

    // Table: write, read, then check flags, bookkeeping and write-back.
    for (int i = 0; i < 6; i++) begin
      wr(tbl[i].addr, tbl[i].wd, tbl[i].inj_sb, tbl[i].inj_db);
      rd_issue(tbl[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(rv_a), 32'h1);
      if (!tbl[i].exp_db) chk($sformatf("v%0d_rd", i), 32'(rd_a), 32'(tbl[i].wd));
      chk($sformatf("v%0d_sb", i), 32'(sb_a), 32'(tbl[i].exp_sb));
      chk($sformatf("v%0d_db", i), 32'(db_a), 32'(tbl[i].exp_db));
      cyc();
      chk($sformatf("v%0d_valid_off", i), 32'(rv_a), 32'h0);
      chk($sformatf("v%0d_sb_gated", i), 32'(sb_a | db_a), 32'h0);
      chk($sformatf("v%0d_err", i), 32'(ea_a), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_sbc", i), 32'(sbc_a), 32'(tbl[i].exp_sbc));
      chk($sformatf("v%0d_dbc", i), 32'(dbc_a), 32'(tbl[i].exp_dbc));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(tbl[i].exp_busy));
      cyc();
      chk($sformatf("v%0d_busy_done", i), 32'(busy_a), 32'h0);
    end

    // Scrubbed row reads clean; DB row is left untouched.
    rd_issue(7'h10);
    chk("scrubbed_rd", 32'(rd_a), 32'h155555);
    chk("scrubbed_sb", 32'(sb_a), 32'h0);
    cyc();
    rd_issue(7'h7F);
    chk("db_again", 32'(db_a), 32'h1);
    cyc();
    chk("db_no_scrub", 32'(busy_a), 32'h0);
    chk("db_cnt3", 32'(dbc_a), 32'h3);

    // Same-address user write during PEND cancels the write-back.
    wr(7'h10, 21'h155555, 1'b1, 1'b0);
    rd_issue(7'h10);
    cyc();
    chk("cancel_busy", 32'(busy_a), 32'h1);
    WEN = 1'b1; WADDR = 7'h10; WD = 21'h000123;
    cyc();
    idle();
    chk("cancel_idle", 32'(busy_a), 32'h0);
    rd_issue(7'h10);
    chk("cancel_rd", 32'(rd_a), 32'h000123);
    chk("cancel_sb", 32'(sb_a), 32'h0);
    cyc();

    // Second SB while PEND and WEN held busy is dropped.
    CNT_CLR = 1'b1;
    cyc();
    idle();
    chk("clr_sbc", 32'(sbc_a), 32'h0);
    wr(7'h01, 21'h0AAAAA, 1'b1, 1'b0);
    wr(7'h02, 21'h055555, 1'b1, 1'b0);
    REN = 1'b1; RADDR = 7'h01;
    cyc();
    REN = 1'b1; RADDR = 7'h02; WEN = 1'b1; WADDR = 7'h30; WD = 21'h00BEEF;
    chk("drop_sb1", 32'(sb_a), 32'h1);
    cyc();
    REN = 1'b0; WEN = 1'b1; WADDR = 7'h31; WD = 21'h00CAFE;
    chk("drop_sb2", 32'(sb_a), 32'h1);
    chk("drop_busy1", 32'(busy_a), 32'h1);
    cyc();
    idle();
    chk("drop_flag", 32'(drop_a), 32'h1);
    chk("drop_busy2", 32'(busy_a), 32'h1);
    chk("drop_sbc", 32'(sbc_a), 32'h2);
    cyc();
    chk("drop_wb_done", 32'(busy_a), 32'h0);
    rd_issue(7'h01);
    chk("drop_row1_rd", 32'(rd_a), 32'h0AAAAA);
    chk("drop_row1_clean", 32'(sb_a), 32'h0);
    cyc();
    rd_issue(7'h02);
    chk("drop_row2_rd", 32'(rd_a), 32'h055555);
    chk("drop_row2_sb", 32'(sb_a), 32'h1);
    cyc(); cyc();
    rd_issue(7'h30);
    chk("drop_user_wr", 32'(rd_a), 32'h00BEEF);
    cyc();
    CNT_CLR = 1'b1;
    cyc();
    idle();
    chk("clr2_sbc", 32'(sbc_a), 32'h0);
    chk("clr2_drop", 32'(drop_a), 32'h0);

    // Reset during PEND: write-back lost, array content kept.
    wr(7'h40, 21'h012345, 1'b1, 1'b0);
    rd_issue(7'h40);
    cyc();
    chk("rstp_busy", 32'(busy_a), 32'h1);
    RESETN = 1'b0;
    #2;
    chk("rstp_busy0", 32'(busy_a), 32'h0);
    chk("rstp_valid", 32'(rv_a), 32'h0);
    chk("rstp_err", 32'(ea_a), 32'h0);
    chk("rstp_dbc", 32'(dbc_a), 32'h0);
    cyc();
    RESETN = 1'b1;
    cyc();
    rd_issue(7'h40);
    chk("rstp_rd", 32'(rd_a), 32'h012345);
    chk("rstp_still_sb", 32'(sb_a), 32'h1);
    cyc(); cyc();

    // RD_PIPE=1 / CNT_W=2 instance.
    RESETN = 1'b0;
    cyc();
    RESETN = 1'b1;
    cyc();
    wr(7'h50, 21'h0ABCDE, 1'b0, 1'b0);
    rd_issue(7'h50);
    chk("pipe_b_early", 32'(rv_b), 32'h0);
    chk("pipe_a_ready", 32'(rv_a), 32'h1);
    cyc();
    chk("pipe_b_valid", 32'(rv_b), 32'h1);
    chk("pipe_b_rd", 32'(rd_b), 32'h0ABCDE);
    chk("pipe_b_sb", 32'(sb_b), 32'h0);
    chk("pipe_a_done", 32'(rv_a), 32'h0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      wr(7'(7'h60 + i), 21'(21'h001000 + i), 1'b1, 1'b0);
      rd_issue(7'(7'h60 + i));
      chk($sformatf("sat%0d_early", i), 32'(rv_b), 32'h0);
      cyc();
      chk($sformatf("sat%0d_valid", i), 32'(rv_b), 32'h1);
      chk($sformatf("sat%0d_sb", i), 32'(sb_b), 32'h1);
      chk($sformatf("sat%0d_rd", i), 32'(rd_b), 32'(21'h001000 + i));
      cyc();
      chk($sformatf("sat%0d_cnt", i), 32'(sbc_b), (i < 3) ? 32'(i + 1) : 32'h3);
      cyc(); cyc();
    end
    chk("sat_a_cnt", 32'(sbc_a), 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
